// File: rtl/clock_enable_manager.sv
// Lock-qualified clock-enable generator: NUM_CH phase-aligned programmable-ratio strobes.
// Optional lock-loss counter output enabled by defining CLOCK_ENABLE_MANAGER_LOSS_CNT_EN.
module clock_enable_manager #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 8,
  parameter int LOCK_WAIT = 16
`ifdef CLOCK_ENABLE_MANAGER_LOSS_CNT_EN
  , parameter int LOSS_CNT_W = 8
`endif
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_locked,
  input  logic [NUM_CH-1:0]       i_ch_en,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic [NUM_CH*DIV_W-1:0] i_phase,
  input  logic                    i_resync,
  output logic [NUM_CH-1:0]       o_ce,
  output logic                    o_valid,
  output logic [1:0]              o_state
`ifdef CLOCK_ENABLE_MANAGER_LOSS_CNT_EN
  , output logic [LOSS_CNT_W-1:0] o_loss_cnt
`endif
);

  localparam int TMR_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       sync_q, sync_d;
  logic             valid_q, valid_d;
  logic             lock_s;
  logic             run_entry, run_stay, run_next;

  assign sync_d = {sync_q[0], i_locked};
  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_LOCK;
        timer_d = '0;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          if (timer_q == TMR_LAST) state_d = ST_RUN;
          else                     timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_RESET;
        timer_d = '0;
      end
    endcase
    // Reset wins over every lock/resync event in the same cycle.
    if (i_reset) begin
      state_d = ST_RESET;
      timer_d = '0;
    end
  end

  assign run_next  = (state_d == ST_RUN);
  assign run_entry = (state_q != ST_RUN) && run_next;
  assign run_stay  = (state_q == ST_RUN) && run_next;
  assign valid_d   = run_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RESET;
      timer_q <= '0;
      sync_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_state = state_q;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d, phase_q, phase_d, cnt_q, cnt_d;
    logic [DIV_W-1:0] d_cur, d_nxt, p_nxt;
    logic             ce_q, ce_d, reload;

    // Settings only change at period boundaries, so a strobe never lands mid-period.
    always_comb begin
      d_cur   = (div_q == '0) ? DIV_W'(1) : div_q;
      reload  = run_entry || (run_stay && (i_resync || (cnt_q == d_cur - DIV_W'(1))));
      div_d   = div_q;
      phase_d = phase_q;
      cnt_d   = '0;
      if (reload) begin
        div_d   = i_div[gi*DIV_W +: DIV_W];
        phase_d = i_phase[gi*DIV_W +: DIV_W];
      end else if (run_stay) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      d_nxt = (div_d == '0) ? DIV_W'(1) : div_d;
      p_nxt = (phase_d >= d_nxt) ? d_nxt - DIV_W'(1) : phase_d;
      ce_d  = run_next && i_ch_en[gi] && (cnt_d == p_nxt);
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        div_q   <= '0;
        phase_q <= '0;
        cnt_q   <= '0;
        ce_q    <= 1'b0;
      end else begin
        div_q   <= div_d;
        phase_q <= phase_d;
        cnt_q   <= cnt_d;
        ce_q    <= ce_d;
      end
    end

    assign o_ce[gi] = ce_q;
  end

`ifdef CLOCK_ENABLE_MANAGER_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q == ST_RUN) && (state_d == ST_WAIT_LOCK) && (loss_cnt_q != '1))
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) loss_cnt_q <= '0;
    else         loss_cnt_q <= loss_cnt_d;
  end

  assign o_loss_cnt = loss_cnt_q;
`else
  // No loss counter in this build; all other behaviour is unchanged.
`endif

endmodule

// File: tb/tb_clock_enable_manager.sv
// Randomised bench for clock_enable_manager against a cycle-level reference model.
// Define CLOCK_ENABLE_MANAGER_LOSS_CNT_EN to also check o_loss_cnt.
module tb_clock_enable_manager;
  localparam int NUM_CH    = 4;
  localparam int DIV_W     = 8;
  localparam int LOCK_WAIT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, locked, resync;
  logic [NUM_CH-1:0]       ch_en, ce;
  logic [NUM_CH*DIV_W-1:0] div, phase;
  logic                    valid;
  logic [1:0]              state;

`ifdef CLOCK_ENABLE_MANAGER_LOSS_CNT_EN
  localparam int LOSS_CNT_W = 8;
  logic [LOSS_CNT_W-1:0] loss_cnt;
`endif

  clock_enable_manager #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_locked(locked), .i_ch_en(ch_en),
    .i_div(div), .i_phase(phase), .i_resync(resync),
    .o_ce(ce), .o_valid(valid), .o_state(state)
`ifdef CLOCK_ENABLE_MANAGER_LOSS_CNT_EN
    , .o_loss_cnt(loss_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pipeline of lock samples, count of consecutive stable samples,
  // and per channel the number of cycles elapsed since its current period began.
  int m_s1, m_s2, m_state, m_stable, m_loss;
  int m_age[NUM_CH];
  int m_div[NUM_CH];
  int m_ph[NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  logic m_valid;

  function automatic int eff_d(input int raw);
    return (raw == 0) ? 1 : raw;
  endfunction

  function automatic int eff_p(input int rawd, input int rawp);
    int d;
    d = eff_d(rawd);
    return (rawp >= d) ? d - 1 : rawp;
  endfunction

  task automatic model_step();
    int  nstate;
    bit  lock_s;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_state = 0; m_stable = 0; m_loss = 0;
      m_ce = '0; m_valid = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin m_age[k] = 0; m_div[k] = 0; m_ph[k] = 0; end
      return;
    end
    lock_s = (m_s2 != 0);
    m_s2   = m_s1;
    m_s1   = int'(locked);
    nstate = m_state;
    case (m_state)
      0: nstate = 1;
      1: begin
        if (lock_s) begin
          m_stable++;
          if (m_stable == LOCK_WAIT) nstate = 2;
        end else begin
          m_stable = 0;
        end
      end
      default: begin
        if (!lock_s) begin
          nstate = 1;
          m_stable = 0;
          if (m_loss < 255) m_loss++;
        end
      end
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (nstate == 2) begin
        if (m_state != 2 || resync || m_age[k] == eff_d(m_div[k]) - 1) begin
          m_div[k] = int'(div[k*DIV_W +: DIV_W]);
          m_ph[k]  = int'(phase[k*DIV_W +: DIV_W]);
          m_age[k] = 0;
        end else begin
          m_age[k]++;
        end
        m_ce[k] = ch_en[k] && (m_age[k] == eff_p(m_div[k], m_ph[k]));
      end else begin
        m_age[k] = 0;
        m_ce[k]  = 1'b0;
      end
    end
    m_valid = (nstate == 2);
    m_state = nstate;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("valid", 64'(valid), 64'(m_valid));
    check("state", 64'(state), 64'(m_state));
    check("ce", 64'(ce), 64'(m_ce));
`ifdef CLOCK_ENABLE_MANAGER_LOSS_CNT_EN
    check("loss_cnt", 64'(loss_cnt), 64'(m_loss));
`endif
  endtask

  task automatic set_ch(input int k, input int d, input int p);
    div[k*DIV_W +: DIV_W]   = DIV_W'(d);
    phase[k*DIV_W +: DIV_W] = DIV_W'(p);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(LOCK_WAIT + 2));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; locked = 1'b0; resync = 1'b0; ch_en = '1; div = '0; phase = '0;
    set_ch(0, 4, 1); set_ch(1, 0, 0); set_ch(2, 3, 7); set_ch(3, 5, 2);
    repeat (3) tick();
    check("rst_ce", 64'(ce), 64'(0));
    rst = 1'b0;
    tick();

    // Steady lock: first o_valid exactly LOCK_WAIT+2 cycles after the rise
    locked = 1'b1;
    wait_valid("lock_latency");
    repeat (12) tick();

    // Ratio change mid-period takes effect only at the wrap
    repeat (2) tick();
    set_ch(0, 6, 1);
    repeat (16) tick();

    // Resync, then lock loss
    resync = 1'b1;
    tick();
    resync = 1'b0;
    repeat (3) tick();
    locked = 1'b0;
    repeat (5) tick();
    check("loss_valid", 64'(valid), 64'(0));

    // Lock glitch restarts the stability timer
    rst = 1'b1; tick(); rst = 1'b0; tick();
    locked = 1'b1; repeat (10) tick();
    locked = 1'b0; repeat (3) tick();
    locked = 1'b1;
    wait_valid("glitch_latency");

    // Reset mid-RUN
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrun_rst_valid", 64'(valid), 64'(0));
    check("midrun_rst_state", 64'(state), 64'(0));
    check("midrun_rst_ce", 64'(ce), 64'(0));
    rst = 1'b0;

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      resync = ($urandom_range(0, 15) == 0);
      ch_en  = NUM_CH'($urandom);
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      if (c < 20) locked = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 19) == 0) set_ch(k, $urandom_range(0, 7), $urandom_range(0, 9));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/clock_enable_manager.md
Name: clock_enable_manager

Overview:
- Parametrised successor to the single-PLL clock unit.
- Takes the fabric clock plus the PLL lock indication and qualifies lock with a synchroniser and a stability timer.
- Produces NUM_CH phase-aligned, programmable-ratio clock-enable strobes and a registered o_valid.
- Downstream ADC/DAC/datapath logic uses one global clock and these strobes instead of extra PLL outputs.

Parameters:
NUM_CH, 4, number of clock-enable channels (1..16)
DIV_W, 8, width of each divide-ratio and phase field
LOCK_WAIT, 16, consecutive synchronised-lock cycles required before RUN (>=1)
LOSS_CNT_W, 8, width of lock-loss counter (optional feature only)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_locked  in  1  PLL lock, asynchronous to i_clock
i_ch_en  in  NUM_CH  per-channel enable
i_div  in  NUM_CH*DIV_W  per-channel divide ratio, channel k at [k*DIV_W +: DIV_W]
i_phase  in  NUM_CH*DIV_W  per-channel strobe phase offset, same packing
i_resync  in  1  single-cycle pulse: realign all channel counters
o_ce  out  NUM_CH  clock-enable strobes, one cycle wide
o_valid  out  1  high while state==RUN (clocks usable)
o_state  out  2  FSM state for debug: 0 RESET, 1 WAIT_LOCK, 2 RUN

Behaviour:
- One clock, i_clock. Reset is synchronous and active-high on i_reset. All outputs are registered.
- Reset values: o_ce=0, o_valid=0, o_state=0, synchroniser=0, lock timer=0, channel counters=0, latched div/phase=0.
- Lock path: i_locked passes through a 2-flop synchroniser to give lock_s, a 2-cycle delay.

FSM:
- RESET: always moves to WAIT_LOCK on the first cycle after i_reset deasserts.
- WAIT_LOCK:
  - Timer increments while lock_s=1 and clears to 0 when lock_s=0.
  - When timer==LOCK_WAIT-1 and lock_s=1, move to RUN.
  - Result: i_locked held high gives first o_valid=1 exactly LOCK_WAIT+2 cycles after its rise.
- RUN:
  - lock_s=0 moves to WAIT_LOCK and clears the timer.
  - o_valid falls on the same edge, 2 cycles after i_locked falls.
  - A lock glitch shorter than 1 cycle may be missed; no requirement applies.
- i_reset high in any state returns to RESET on that edge and overrides every other event.

Channels, each independent:
- Divide ratio: D = latched div; D=0 is treated as 1.
- Phase: P = latched phase; if P>=D, P is clamped to D-1.
- Counter behaviour: counts 0..D-1 and wraps to 0.
- Strobe: o_ce[k]=1 in the cycle where counter==P, o_valid=1 and i_ch_en[k]=1. D=1 therefore strobes every cycle.
- Counters and o_ce are held at 0 outside RUN.
- On RUN entry, all counters start at 0 together, so phase-aligned.
- i_ch_en[k] gates only the strobe; the counter keeps running so the channel stays aligned when re-enabled.
- Ratio/phase updates: i_div and i_phase for a channel are latched on RUN entry, at that channel's wrap (counter==D-1), and on i_resync. No partial-period strobes.
- i_resync in RUN: next cycle all counters are 0, with freshly latched div/phase. It is ignored outside RUN.
- Simultaneous events: a wrap and i_resync in the same cycle behave as a resync. Lock loss and i_resync in the same cycle behave as lock loss.

Optional Feature:
- Macro: CLOCK_ENABLE_MANAGER_LOSS_CNT_EN.
- Defined:
  - Adds output o_loss_cnt [LOSS_CNT_W-1:0].
  - Increments once per RUN→WAIT_LOCK transition.
  - Saturates at all-ones.
  - Cleared only by i_reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then i_locked=1 steady, LOCK_WAIT=16 -> o_valid and o_state=2 first seen 18 cycles after i_locked rise; o_ce=0 before that.
- i_locked pulses high 10 cycles, low 3, then high steady -> timer restarts; o_valid rises 18 cycles after the second rise.
- RUN with ch0 div=4 phase=1, ch1 div=0, ch2 div=3 phase=7 -> ch0 strobes at RUN cycles 1,5,9...; ch1 strobes every cycle; ch2 clamps to phase 2, strobing at cycles 2,5,8.
- ch0 div changed 4→6 mid-period -> old 4-cycle period completes, then a 6-cycle period; no short pulse.
- i_resync at arbitrary cycle, then i_locked dropped in RUN -> all counters 0 the following cycle; after the drop, o_valid=0 and o_ce=0 two cycles later; with the macro defined, o_loss_cnt=1.
- i_reset asserted mid-RUN -> next cycle all outputs at reset values.
